// File: rtl/paralelo_serial_tx.sv
// Transmit-side serializer: sends a comma preamble after reset, then MSB-first user bytes at clk_32f.
// Optional TX_BYTE_COUNT_EN adds a 16-bit count of accepted user bytes on tx_count.
module paralelo_serial_tx #(
  parameter int unsigned SYNC_COMMAS = 6,  // legal range 5..15 (comma counter is 4 bits)
  parameter logic [7:0]  COMMA       = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        active
`ifdef TX_BYTE_COUNT_EN
  ,
  output logic [15:0] tx_count
`endif
);

  typedef enum logic {StSync, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        data_out_q, data_out_d;
  logic [3:0]  comma_cnt_q, comma_cnt_d;
  logic        slot_start;
  logic        accept;
  logic [7:0]  byte_sel;

  assign slot_start = (bit_cnt_q == 3'd0);

  // FSM: state register
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; leave SYNC on the edge that loads the last preamble comma
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: begin
        if (slot_start && (comma_cnt_q == 4'(SYNC_COMMAS - 1))) begin
          state_d = StActive;
        end
      end
      StActive: state_d = StActive;
      default:  state_d = StSync;
    endcase
  end

  // FSM: Moore outputs, derived from registered state only
  always_comb begin
    active    = (state_q == StActive);
    ready_out = (state_q == StActive) && slot_start;
  end

  assign accept   = ready_out && valid_in;
  assign byte_sel = accept ? data_in : COMMA;

  always_comb begin
    if (slot_start) begin
      data_out_d = byte_sel[7];
      shift_d    = {byte_sel[6:0], 1'b0};
      bit_cnt_d  = 3'd1;
    end else begin
      data_out_d = shift_q[7];
      shift_d    = {shift_q[6:0], 1'b0};
      bit_cnt_d  = bit_cnt_q + 3'd1;  // 7 -> 0 wrap marks the next slot
    end
  end

  always_comb begin
    comma_cnt_d = comma_cnt_q;
    if ((state_q == StSync) && slot_start) begin
      comma_cnt_d = comma_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      data_out_q  <= 1'b0;
      comma_cnt_q <= 4'd0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  assign data_out = data_out_q;

`ifdef TX_BYTE_COUNT_EN
  logic [15:0] tx_count_q;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      tx_count_q <= 16'd0;
    end else if (accept) begin
      tx_count_q <= tx_count_q + 16'd1;
    end
  end

  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: the stimulus side predicts each output bit from slot
// arithmetic; a monitor pops and compares after every clock edge.
module tb_paralelo_serial_tx;

  localparam int unsigned SYNC_COMMAS = 6;
  localparam logic [7:0]  COMMA       = 8'hBC;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active;
`ifdef TX_BYTE_COUNT_EN
  logic [15:0] tx_count;
`endif

  paralelo_serial_tx #(
    .SYNC_COMMAS (SYNC_COMMAS),
    .COMMA       (COMMA)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active    (active)
`ifdef TX_BYTE_COUNT_EN
    ,
    .tx_count  (tx_count)
`endif
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic        sbit;
    logic        act;
    logic        rdy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned total;
  int unsigned bad;
  bit          mon_on;
  int unsigned slot_idx;  // slots since reset release
  int unsigned acc_cnt;   // user bytes accepted since reset release

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge while enabled
  initial begin
    forever begin
      @(posedge clk_32f);
      #1;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 16'd1, 16'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", 16'(data_out), 16'(e.sbit));
          check("active", 16'(active), 16'(e.act));
          check("ready_out", 16'(ready_out), 16'(e.rdy));
`ifdef TX_BYTE_COUNT_EN
          check("tx_count", tx_count, e.cnt);
`endif
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 16'(data_out), 16'd0);
    check({tag, "_active"}, 16'(active), 16'd0);
    check({tag, "_ready_out"}, 16'(ready_out), 16'd0);
`ifdef TX_BYTE_COUNT_EN
    check({tag, "_tx_count"}, tx_count, 16'd0);
`endif
  endtask

  // Assert reset now, check outputs clear at once, release on a later falling edge
  task automatic do_reset();
    reset  = 1'b0;
    mon_on = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_reset");
    slot_idx = 0;
    acc_cnt  = 0;
    repeat (2) @(negedge clk_32f);
    reset  = 1'b1;
    mon_on = 1'b1;
  endtask

  // Called on the falling edge before a slot boundary. Predicts all eight edges of the slot,
  // then scrambles the inputs between boundaries. abort_after>=0 resets after that edge index.
  task automatic run_slot(input bit v, input logic [7:0] d, input int abort_after);
    logic [7:0] b;
    bit         acc;
    exp_t       e;
    valid_in = v;
    data_in  = d;
    acc      = (slot_idx >= SYNC_COMMAS) && v;
    b        = acc ? d : COMMA;
    if (acc) acc_cnt++;
    for (int i = 0; i < 8; i++) begin
      e.sbit = b[7-i];
      e.act  = (slot_idx >= SYNC_COMMAS - 1);
      e.rdy  = e.act && (i == 7);
      e.cnt  = 16'(acc_cnt);
      exp_q.push_back(e);
    end
    slot_idx++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_32f);
      if (i == abort_after) begin
        #3;
        do_reset();
        return;
      end
      @(negedge clk_32f);
      if (i < 7) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = 8'($urandom);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    mon_on   = 1'b0;
    slot_idx = 0;
    acc_cnt  = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk_32f);
    check_reset_outputs("reset");
    reset  = 1'b1;
    mon_on = 1'b1;

    // Preamble: inputs must be ignored until ACTIVE
    for (int s = 0; s < int'(SYNC_COMMAS); s++) begin
      run_slot(1'($urandom_range(0, 1)), 8'($urandom), -1);
    end
    run_slot(1'b1, 8'hA5, -1);
    run_slot(1'b1, 8'h00, -1);
    run_slot(1'b1, 8'hFF, -1);
    run_slot(1'b0, 8'h3C, -1);
    run_slot(1'b1, 8'h5A, -1);
    for (int s = 0; s < 20; s++) begin
      run_slot(1'($urandom_range(0, 1)), 8'($urandom), -1);
    end
    // Abort mid-byte after the fourth edge of the slot
    run_slot(1'b1, 8'hC3, 3);
    for (int s = 0; s < int'(SYNC_COMMAS); s++) begin
      run_slot(1'($urandom_range(0, 1)), 8'($urandom), -1);
    end
    run_slot(1'b1, 8'h81, -1);
    for (int s = 0; s < 6; s++) begin
      run_slot(1'($urandom_range(0, 1)), 8'($urandom), -1);
    end
    check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
